// File: rtl/key_input_pkg.sv
// Shared constants and register decode for the key_input peripheral.
package key_input_pkg;

  localparam logic [31:0] ADDR_VER    = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
  localparam logic [31:0] ADDR_EVENT  = 32'h0000_0008;
  localparam logic [31:0] ADDR_IRQEN  = 32'h0000_000C;

  localparam logic [31:0] HW_VER = 32'h0000_0001;

  // Register selected by a bus address; only exact matches decode.
  typedef enum logic [2:0] {
    REG_VER,
    REG_STATUS,
    REG_EVENT,
    REG_IRQEN,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      ADDR_VER:    sel = REG_VER;
      ADDR_STATUS: sel = REG_STATUS;
      ADDR_EVENT:  sel = REG_EVENT;
      ADDR_IRQEN:  sel = REG_IRQEN;
      default:     sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/key_input_if.sv
// CPU register bus: single-cycle write strobe and registered read port.
interface key_input_if;

  logic        wr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        rd;
  logic [31:0] raddr;
  logic [31:0] rdata;

  modport master (
    output wr, waddr, wdata, rd, raddr,
    input  rdata
  );

  modport slave (
    input  wr, waddr, wdata, rd, raddr,
    output rdata
  );

endinterface

// File: rtl/key_debounce.sv
// One key channel: 2-FF synchronizer on the inverted pin, debounce counter,
// debounced level and a one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_pin,
  output logic stable,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          accept;

  // Level change is accepted on the cycle the count of disagreeing samples completes.
  always_comb begin
    accept = (sync != stable) && (cnt == CNT_LAST);
    press  = accept && sync;
  end

  // Synchronizer, counter and debounced level; all reset to released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_1 <= 1'b0;
      sync   <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_1 <= ~key_pin;
      sync   <= sync_1;
      if (sync == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_input.sv
// Memory-mapped push-button peripheral: debounced STATUS, sticky W1C EVENT
// flags, IRQ_EN mask and a level interrupt.
module key_input
  import key_input_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rstn,
  key_input_if.slave        bus,
  input  logic [N_KEYS-1:0] key_pin,
  output logic              irq
);

  // Bits above N_KEYS are held at zero; keeping the registers 32 bits wide
  // lets every write-data bit feed the masked update.
  localparam logic [31:0] KEY_MASK =
    (N_KEYS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << N_KEYS) - 32'd1);

  logic [N_KEYS-1:0] status;
  logic [N_KEYS-1:0] press;
  logic [31:0]       event_q;
  logic [31:0]       irqen_q;
  logic [31:0]       w1c;
  logic [31:0]       rmux;
  reg_sel_e          wsel;
  reg_sel_e          rsel;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rstn   (rstn),
      .key_pin(key_pin[g]),
      .stable (status[g]),
      .press  (press[g])
    );
  end

  // Address decode and the write-1-to-clear mask for EVENT.
  always_comb begin
    wsel = decode_addr(bus.waddr);
    rsel = decode_addr(bus.raddr);
    w1c  = '0;
    if (bus.wr && (wsel == REG_EVENT)) begin
      w1c = bus.wdata & KEY_MASK;
    end
  end

  // Sticky event flags and interrupt enable; a press in the same cycle as
  // its clear keeps the bit set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      event_q <= '0;
      irqen_q <= '0;
    end else begin
      event_q <= (event_q & ~w1c) | 32'(press);
      if (bus.wr && (wsel == REG_IRQEN)) begin
        irqen_q <= bus.wdata & KEY_MASK;
      end
    end
  end

  // Read mux over the pre-update register values.
  always_comb begin
    rmux = '0;
    case (rsel)
      REG_VER:    rmux = HW_VER;
      REG_STATUS: rmux = 32'(status);
      REG_EVENT:  rmux = event_q;
      REG_IRQEN:  rmux = irqen_q;
      default:    rmux = '0;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.rdata <= '0;
    end else if (bus.rd) begin
      bus.rdata <= rmux;
    end
  end

  // Level interrupt from registered flags and mask.
  always_comb begin
    irq = |(event_q & irqen_q);
  end

endmodule

// File: tb/tb_key_input.sv
// Self-checking bench for key_input with N_KEYS=4, DEBOUNCE_CYCLES=8.
module tb_key_input;

  localparam int unsigned NK = 4;
  localparam int unsigned DC = 8;
  localparam logic [63:0] WMASK = (64'd1 << DC) - 64'd1;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NK-1:0] key_pin;
  logic          irq;

  key_input_if bus_if ();

  key_input #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus_if),
    .key_pin(key_pin),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a key's level is accepted once the last DC synchronized
  // samples all disagree with the current level; samples lag the pin by two edges.
  logic [63:0]   hist [NK];
  logic [NK-1:0] m_stable;
  logic [NK-1:0] m_event;
  logic [NK-1:0] m_irqen;
  logic [NK-1:0] m_press;
  logic [31:0]   m_rdata;
  logic          m_irq;
  logic [63:0]   win;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h1;
      32'h4:   return 32'(m_stable);
      32'h8:   return 32'(m_event);
      32'hC:   return 32'(m_irqen);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < NK; k++) hist[k] = '0;
      m_stable = '0;
      m_event  = '0;
      m_irqen  = '0;
      m_rdata  = '0;
      m_irq    = 1'b0;
    end else begin
      if (bus_if.rd) m_rdata = m_read(bus_if.raddr);
      m_press = '0;
      for (int unsigned k = 0; k < NK; k++) begin
        win = (hist[k] >> 1) & WMASK;
        if (!m_stable[k] && win == WMASK) begin
          m_stable[k] = 1'b1;
          m_press[k]  = 1'b1;
        end else if (m_stable[k] && win == 64'd0) begin
          m_stable[k] = 1'b0;
        end
        hist[k] = {hist[k][62:0], ~key_pin[k]};
      end
      if (bus_if.wr && bus_if.waddr == 32'h8) m_event = m_event & ~bus_if.wdata[NK-1:0];
      if (bus_if.wr && bus_if.waddr == 32'hC) m_irqen = bus_if.wdata[NK-1:0];
      m_event = m_event | m_press;
      m_irq   = |(m_event & m_irqen);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: outputs sampled on the falling edge against the model.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("rdata_model", bus_if.rdata, m_rdata);
    chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus_if.rd    = 1'b1;
    bus_if.raddr = a;
    tick();
    bus_if.rd = 1'b0;
    chk(tag, bus_if.rdata, exp);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus_if.wr    = 1'b1;
    bus_if.waddr = a;
    bus_if.wdata = d;
    tick();
    bus_if.wr = 1'b0;
  endtask

  // Reads STATUS at 9 and 10 edges after a pin or reset edge made just before.
  task automatic status_window(input logic [31:0] at9, input logic [31:0] at10, input string tag);
    ticks(9);
    bus_if.rd    = 1'b1;
    bus_if.raddr = 32'h4;
    tick();
    chk({tag, "_at9"}, bus_if.rdata, at9);
    tick();
    chk({tag, "_at10"}, bus_if.rdata, at10);
    bus_if.rd = 1'b0;
  endtask

  int unsigned hold [NK];
  logic [31:0] addr_tab [6];

  initial begin
    addr_tab[0] = 32'h0;  addr_tab[1] = 32'h4;  addr_tab[2] = 32'h8;
    addr_tab[3] = 32'hC;  addr_tab[4] = 32'h10; addr_tab[5] = 32'h109;

    rstn         = 1'b0;
    key_pin      = '1;
    bus_if.wr    = 1'b0;
    bus_if.waddr = '0;
    bus_if.wdata = '0;
    bus_if.rd    = 1'b0;
    bus_if.raddr = '0;
    @(negedge clk);
    chk("reset_rdata", bus_if.rdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    ticks(3);
    rstn = 1'b1;
    tick();

    // Register map after reset.
    rd_reg(32'h0,  32'h1, "read_ver");
    rd_reg(32'h4,  32'h0, "read_status");
    rd_reg(32'h8,  32'h0, "read_event");
    rd_reg(32'hC,  32'h0, "read_irqen");
    rd_reg(32'h10, 32'h0, "read_unmapped");
    wr_reg(32'h0, 32'hFF);
    rd_reg(32'h0,  32'h1, "ver_after_write");

    // Key 1 press and release latency.
    key_pin[1] = 1'b0;
    status_window(32'h0, 32'h2, "press1");
    rd_reg(32'h8, 32'h2, "event1");
    key_pin[1] = 1'b1;
    status_window(32'h2, 32'h0, "release1");
    rd_reg(32'h8, 32'h2, "event1_after_release");

    // Key 2 bounce never accepted.
    bus_if.rd    = 1'b1;
    bus_if.raddr = 32'h4;
    for (int r = 0; r < 4; r++) begin
      key_pin[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin tick(); chk("bounce_status", bus_if.rdata, 32'h0); end
      key_pin[2] = 1'b1;
      for (int i = 0; i < 2; i++) begin tick(); chk("bounce_status", bus_if.rdata, 32'h0); end
    end
    bus_if.rd = 1'b0;
    ticks(12);
    rd_reg(32'h4, 32'h0, "bounce_status_end");
    rd_reg(32'h8, 32'h2, "bounce_event_end");

    // Interrupt enable and write-1-to-clear.
    wr_reg(32'hC, 32'hFFFF_FFF2);
    chk("irq_on_enable", {31'b0, irq}, 32'h1);
    rd_reg(32'hC, 32'h2, "irqen_masked");
    wr_reg(32'h8, 32'h0);
    chk("irq_after_w0", {31'b0, irq}, 32'h1);
    rd_reg(32'h8, 32'h2, "event_after_w0");
    wr_reg(32'h8, 32'h2);
    chk("irq_after_w1c", {31'b0, irq}, 32'h0);
    rd_reg(32'h8, 32'h0, "event_after_w1c");

    // Read and write of the same register in one cycle returns the old value.
    bus_if.rd    = 1'b1;
    bus_if.raddr = 32'hC;
    wr_reg(32'hC, 32'h5);
    bus_if.rd = 1'b0;
    chk("rd_wr_same", bus_if.rdata, 32'h2);
    rd_reg(32'hC, 32'h5, "irqen_new");
    wr_reg(32'hC, 32'h2);

    // Clear of bit 3 on the acceptance edge of key 3: set wins.
    key_pin[3] = 1'b0;
    ticks(9);
    wr_reg(32'h8, 32'h8);
    rd_reg(32'h8, 32'h8, "set_wins");
    rd_reg(32'h4, 32'h8, "status3");
    key_pin[3] = 1'b1;
    ticks(12);

    // Reset in the middle of a key 0 debounce.
    key_pin[0] = 1'b0;
    ticks(4);
    rstn = 1'b0;
    ticks(3);
    rstn = 1'b1;
    status_window(32'h0, 32'h1, "held_thru_reset");
    rd_reg(32'h8, 32'h1, "event_thru_reset");
    rd_reg(32'hC, 32'h0, "irqen_thru_reset");
    key_pin[0] = 1'b1;
    ticks(12);

    // Randomized pins and bus traffic against the model.
    for (int unsigned k = 0; k < NK; k++) hold[k] = $urandom_range(1, 24);
    for (int c = 0; c < 2000; c++) begin
      for (int unsigned k = 0; k < NK; k++) begin
        hold[k]--;
        if (hold[k] == 0) begin
          key_pin[k] = ~key_pin[k];
          hold[k]    = $urandom_range(1, 24);
        end
      end
      bus_if.rd    = 1'($urandom_range(0, 1));
      bus_if.raddr = addr_tab[$urandom_range(0, 5)];
      bus_if.wr    = ($urandom_range(0, 7) == 0);
      bus_if.waddr = addr_tab[$urandom_range(0, 5)];
      bus_if.wdata = $urandom;
      tick();
    end
    bus_if.rd = 1'b0;
    bus_if.wr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_input.md
# key_input

Memory-mapped push-button input peripheral on the CPU register bus, the read-side counterpart of the bus-written output peripherals. It synchronizes and debounces N active-low key pins, reports their debounced level, latches press events into sticky write-1-to-clear flags, and raises a level interrupt for enabled events. The CPU reads registers over a registered read port; writes use the same `wr`/`waddr`/`wdata` bus as the other peripherals.

## Interface
- `N_KEYS`, default 4: number of key pins, 1..32.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change, ≥2. The default is 10 ms at 50 MHz.
- `clk` in 1: single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `wr` in 1: write strobe, one cycle per write.
- `waddr` in 32: write byte address.
- `wdata` in 32: write data.
- `rd` in 1: read strobe.
- `raddr` in 32: read byte address.
- `rdata` out 32: read data. It is registered and valid the cycle after `rd`.
- `key_pin` in N_KEYS: raw key pins, asynchronous, 0 = pressed.
- `irq` out 1: level interrupt, `|(EVENT & IRQ_EN)`.

## Operation
Register map. Addresses are byte addresses; only exact matches decode.
- 0x0 VER: read-only, returns HW_VER = 0x01. Writes are ignored.
- 0x4 STATUS: read-only. Bit i = 1 while key i is debounced-pressed. Upper bits read 0.
- 0x8 EVENT: sticky press flags. Bit i sets on the debounced released→pressed transition of key i. Writing 1 clears the bit; writing 0 has no effect. Reading does not clear.
- 0xC IRQ_EN: read/write, bits [N_KEYS-1:0]. Unused bits are written-ignored and read 0.

Unmapped read addresses return 0. Unmapped writes are ignored.

Per-key processing:
- 2-FF synchronizer on the inverted pin, giving `sync` (1 = pressed).
- Debounce counter, width clog2(DEBOUNCE_CYCLES):
  - When `sync == stable`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and `sync != stable` still holds, `stable` takes `sync` and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES restarts the count and never changes `stable`.
- Press event: `stable` going 0→1 pulses `press` for one cycle. Release generates no event.

Boundary rules:
- **Simultaneous press and W1C on the same bit:** set wins, so the bit stays 1.
- **Repeated presses before clear:** the bit stays 1; there is no counter or overflow.
- **IRQ_EN write:** takes effect the next cycle. Enabling a bit whose EVENT is already 1 asserts `irq` immediately.
- **Simultaneous `rd` and `wr` to the same register:** `rdata` returns the pre-write value.
- **Reset mid-debounce:** all counters, synchronizers and `stable` reset to 0 (released). A key held through reset is accepted as a press 2+DEBOUNCE_CYCLES cycles after `rstn` deasserts, and it sets EVENT.

## Timing
Reset values:
- `rdata` = 0, `irq` = 0.
- STATUS = 0, EVENT = 0, IRQ_EN = 0.
- Synchronizer flops = 0, i.e. released.

Latencies:
- Pin edge to `sync`: 2 cycles.
- `sync` change to STATUS/EVENT update: DEBOUNCE_CYCLES cycles, so pin to register is 2+DEBOUNCE_CYCLES clocks.
- `irq` is combinational from registered EVENT and IRQ_EN. It asserts the same cycle EVENT updates and drops the cycle after the clearing write.
- Read: `rd` at edge k gives `rdata` valid after edge k+1, held until the next `rd`. No wait states.
- Write: takes effect at the edge where `wr` is sampled.

## Structure
- Shared package `key_input_pkg` holds:
  - address constants ADDR_VER=0x0, ADDR_STATUS=0x4, ADDR_EVENT=0x8, ADDR_IRQEN=0xC;
  - HW_VER=32'h01.
- Sub-module `key_debounce` is one channel: synchronizer, counter, `stable`, `press` pulse, parameter DEBOUNCE_CYCLES. It is instantiated N_KEYS times in a generate loop.
- The top level holds the register file, read mux and `irq`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and N_KEYS=4.
1. Reset, then read 0x0/0x4/0x8/0xC/0x10 → 0x01, 0, 0, 0, 0. `irq` = 0 throughout.
2. Drive `key_pin[1]`=0 and hold → STATUS reads 0x2 and EVENT reads 0x2 exactly 10 cycles after the pin edge, not at 9. Release → STATUS back to 0 after 10 cycles; EVENT stays 0x2.
3. Bounce `key_pin[2]` low for 5 cycles and high for 2, repeated 4 times, then release → STATUS and EVENT never change from 0.
4. Write IRQ_EN=0x2 with EVENT=0x2 → `irq`=1 next cycle. Write 0x0 to 0x8 → no change. Write 0x2 to 0x8 → EVENT=0 and `irq`=0 on the following cycle.
5. Time a W1C of bit 3 to the same edge as the key-3 press acceptance → EVENT bit 3 = 1 afterwards.
6. Hold `key_pin[0]`=0, assert `rstn`=0 mid-debounce for 3 cycles, then release reset → STATUS=0x1 and EVENT=0x1 at 10 cycles after reset deassertion.
